pairing_uart_loader: RTL and testbench
======================================

Name: pairing_uart_loader

Overview:
- Host-to-core write path for BN254_pairing: serial 8N1 UART receiver that assembles packets into full-width operand words and writes them through the core's extin_addr/extin_data/extin_en port.
- Complements the existing readout path, which shifts extout_data out serially.
- Packet format: 1 address byte, then DATA_W/8 data bytes, most-significant byte first.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4.
- DATA_W, 304, extin_data width; multiple of 8.
- ADDR_W, 8, extin_addr width; must be <= 8.

Ports:
- clk  in  1  core clock; all logic on posedge.
- rstn  in  1  asynchronous, active-low reset.
- uart_tx  in  1  host-to-FPGA serial line; idle high; asynchronous to clk.
- extin_addr  out  ADDR_W  write address, latched from the packet address byte (low ADDR_W bits).
- extin_data  out  DATA_W  assembled word.
- extin_en  out  1  one-cycle write strobe.
- busy  out  1  high from the start bit of the address byte until extin_en or abort.
- err_frame  out  1  one-cycle pulse on stop-bit error.

Behaviour:
- Reset (async, rstn=0): all outputs 0; synchronizer flops 1; both FSMs to idle; byte counter 0.
- Input sync: uart_tx passes through 2 flops to give rx_s. All decisions use rx_s only.
- Bit FSM states: B_IDLE, B_START, B_DATA, B_STOP.
  - B_IDLE: on rx_s=0, clear the tick counter and go to B_START.
  - B_START: at count CLKS_PER_BIT/2-1 (floor), sample rx_s.
    - 1: false start; return to B_IDLE, no error.
    - 0: go to B_DATA with bit index 0.
  - B_DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first. After bit 7, go to B_STOP.
  - B_STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - 1: byte_valid pulses for one cycle with the byte value.
    - 0: err_frame pulses for one cycle.
    - Either way, return to B_IDLE.
- Packet FSM states: P_ADDR, P_DATA, P_WRITE.
  - P_ADDR: on byte_valid, latch the address byte into an internal register, clear byte count, go to P_DATA.
  - P_DATA: on byte_valid, shift the word register left by 8 and insert the byte at [7:0]; increment count. When count reaches DATA_W/8, go to P_WRITE.
  - P_WRITE: one cycle.
    - extin_addr <= latched address; extin_data <= word; extin_en=1.
    - Return to P_ADDR and clear the word register.
- Output timing:
  - extin_en asserts exactly 2 clk after the byte_valid of the last data byte.
  - extin_addr and extin_data are registered. They change only in the P_WRITE cycle and hold until the next write.
  - extin_en is 0 in every other cycle.
- Frame error in any packet state: abort the packet, discard partial data, clear count, go to P_ADDR, deassert busy. No extin_en is issued. The next valid byte is treated as an address.
- busy:
  - Set on the start-bit detect that begins an address byte.
  - Cleared in the P_WRITE cycle or on abort.
  - A false start on the address byte also clears busy.
- Byte count: width clog2(DATA_W/8)+1; never wraps past DATA_W/8.
- No flow control: the host must not start a new packet before extin_en. Back-to-back packets with zero idle gap between stop and next start bit must work, because P_WRITE takes fewer cycles than half a bit.
- Reset mid-packet discards all state. Reset mid-byte may leave the line low; the receiver resumes only on a fresh high-to-low edge observed after reset, i.e. B_IDLE requires rx_s=1 for at least one cycle before accepting a start.

Test Plan:
- Basic write (CLKS_PER_BIT=8, DATA_W=304): send 0x05, then bytes 0x01..0x26 → one extin_en pulse; extin_addr=0x05; extin_data=0x0102…2526 (byte 0x01 in [303:296], 0x26 in [7:0]); busy falls the same cycle.
- Glitch: drive uart_tx low for 2 clk during idle → no byte, no err_frame, busy returns 0, no extin_en.
- Frame error: send 0x10 and 5 data bytes, 6th byte with stop=0 → err_frame pulses once; no extin_en. Then a full packet to 0x11 writes correctly with no stale bytes.
- Back-to-back: two packets with zero gap (0x01 / all 0xAA, then 0x02 / all 0x55) → exactly two extin_en pulses with the correct addr/data each, and outputs held between them.
- Reset mid-packet: assert rstn low after 10 data bytes → outputs 0 asynchronously. After release, a full packet to 0x07 writes with 0x07 and the correct data.
- Hold check: after a write, send a partial packet (address + 3 bytes) → extin_data/extin_addr unchanged and extin_en stays 0.

Source files
------------

// File: rtl/pairing_uart_loader.sv
// pairing_uart_loader
//   Host-to-core write path for the BN254 pairing core. An 8N1 UART receiver
//   collects packets and writes each one through the core's external input
//   port. A packet is one address byte followed by DATA_W/8 data bytes,
//   most-significant byte first.
//
// Ports:
//   clk         core clock; all logic on posedge
//   rstn        asynchronous active-low reset
//   uart_tx     host-to-FPGA serial line, idle high, asynchronous to clk
//   extin_addr  write address (low ADDR_W bits of the packet address byte)
//   extin_data  assembled DATA_W-bit word
//   extin_en    one-cycle write strobe
//   busy        high from the address start bit until the write or an abort
//   err_frame   one-cycle pulse when a stop bit is sampled low
module pairing_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 304,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              uart_tx,
  output logic [ADDR_W-1:0] extin_addr,
  output logic [DATA_W-1:0] extin_data,
  output logic              extin_en,
  output logic              busy,
  output logic              err_frame
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BCNT_W = $clog2(NBYTES) + 1;
  localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BCNT_W-1:0] LAST_M1 = BCNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
  typedef enum logic [1:0] {P_ADDR, P_DATA, P_WRITE} pkt_state_t;

  // ---------------------------------------------------------------------
  // Input synchronizer. The flops reset high so the line looks idle.
  // ---------------------------------------------------------------------
  logic [1:0] sync_reg;
  logic       rx_s;
  // Counts the cycles since reset until the synchronizer holds real line
  // samples; the reset value of the flops must not count as "line high".
  logic [1:0] settle_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_reg   <= 2'b11;
      settle_reg <= 2'd0;
    end else begin
      sync_reg <= {sync_reg[0], uart_tx};
      if (settle_reg != 2'd3) settle_reg <= settle_reg + 2'd1;
    end
  end

  assign rx_s = sync_reg[1];

  // ---------------------------------------------------------------------
  // Bit FSM
  // ---------------------------------------------------------------------
  bit_state_t       bstate_reg, bstate_next;
  logic [CNT_W-1:0] tick_reg, tick_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  // Set once the line has been seen high in idle; a start bit is only
  // accepted as a genuine high-to-low edge.
  logic             armed_reg, armed_next;
  logic             byte_valid_reg, byte_valid_next;
  logic             frame_err_reg, frame_err_next;
  logic             start_det, false_start;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bstate_reg     <= B_IDLE;
      tick_reg       <= '0;
      bit_idx_reg    <= 3'd0;
      shift_reg      <= 8'd0;
      armed_reg      <= 1'b0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      bstate_reg     <= bstate_next;
      tick_reg       <= tick_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
      armed_reg      <= armed_next;
      byte_valid_reg <= byte_valid_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    bstate_next     = bstate_reg;
    tick_next       = tick_reg + 1'b1;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    armed_next      = armed_reg;
    byte_valid_next = 1'b0;
    frame_err_next  = 1'b0;
    start_det       = 1'b0;
    false_start     = 1'b0;
    case (bstate_reg)
      B_IDLE: begin
        tick_next = '0;
        if (rx_s) begin
          if (settle_reg == 2'd3) armed_next = 1'b1;
        end else if (armed_reg) begin
          start_det   = 1'b1;
          bstate_next = B_START;
        end
      end
      B_START: begin
        if (tick_reg == HALF_M1) begin
          tick_next = '0;
          if (rx_s) begin
            false_start = 1'b1;
            bstate_next = B_IDLE;
          end else begin
            bit_idx_next = 3'd0;
            bstate_next  = B_DATA;
          end
        end
      end
      B_DATA: begin
        if (tick_reg == FULL_M1) begin
          tick_next    = '0;
          shift_next   = {rx_s, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) bstate_next = B_STOP;
        end
      end
      B_STOP: begin
        if (tick_reg == FULL_M1) begin
          tick_next   = '0;
          bstate_next = B_IDLE;
          if (rx_s) begin
            byte_valid_next = 1'b1;
          end else begin
            frame_err_next = 1'b1;
            // Line is low right now: wait for it to return high first.
            armed_next     = 1'b0;
          end
        end
      end
      default: bstate_next = B_IDLE;
    endcase
  end

  assign err_frame = frame_err_reg;

  // ---------------------------------------------------------------------
  // Packet FSM
  // ---------------------------------------------------------------------
  pkt_state_t        pstate_reg, pstate_next;
  logic [7:0]        addr_reg;
  logic [DATA_W-1:0] word_reg;
  logic [BCNT_W-1:0] bcnt_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pstate_reg <= P_ADDR;
    else       pstate_reg <= pstate_next;
  end

  always_comb begin
    pstate_next = pstate_reg;
    case (pstate_reg)
      P_ADDR:  if (byte_valid_reg) pstate_next = P_DATA;
      P_DATA:  if (byte_valid_reg && bcnt_reg == LAST_M1) pstate_next = P_WRITE;
      P_WRITE: pstate_next = P_ADDR;
      default: pstate_next = P_ADDR;
    endcase
    // A frame error anywhere abandons the packet.
    if (frame_err_reg) pstate_next = P_ADDR;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_reg   <= 8'd0;
      word_reg   <= '0;
      bcnt_reg   <= '0;
      extin_addr <= '0;
      extin_data <= '0;
      extin_en   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      extin_en <= 1'b0;
      case (pstate_reg)
        P_ADDR: begin
          if (byte_valid_reg) begin
            addr_reg <= shift_reg;
            bcnt_reg <= '0;
          end
        end
        P_DATA: begin
          if (byte_valid_reg) begin
            word_reg <= {word_reg[DATA_W-9:0], shift_reg};
            bcnt_reg <= bcnt_reg + 1'b1;
          end
        end
        P_WRITE: begin
          extin_addr <= addr_reg[ADDR_W-1:0];
          extin_data <= word_reg;
          extin_en   <= 1'b1;
          busy       <= 1'b0;
          word_reg   <= '0;
          bcnt_reg   <= '0;
        end
        default: ;
      endcase
      // busy only tracks the address byte's start bit; data-byte start
      // bits (and their glitches) leave it alone.
      if (pstate_reg == P_ADDR) begin
        if (start_det)   busy <= 1'b1;
        if (false_start) busy <= 1'b0;
      end
      if (frame_err_reg) begin
        word_reg <= '0;
        bcnt_reg <= '0;
        busy     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pairing_uart_loader.sv
// tb_pairing_uart_loader
//   Self-checking bench for pairing_uart_loader with CLKS_PER_BIT=8,
//   DATA_W=304, ADDR_W=8. Serial frames are driven bit by bit; every write
//   seen on the extin port is captured and compared against words built
//   directly from the byte lists that were sent.
module tb_pairing_uart_loader;

  localparam int CPB    = 8;
  localparam int DATA_W = 304;
  localparam int ADDR_W = 8;
  localparam int NB     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              uart_tx = 1'b1;
  logic [ADDR_W-1:0] extin_addr;
  logic [DATA_W-1:0] extin_data;
  logic              extin_en;
  logic              busy;
  logic              err_frame;

  pairing_uart_loader #(.CLKS_PER_BIT(CPB), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .uart_tx    (uart_tx),
    .extin_addr (extin_addr),
    .extin_data (extin_data),
    .extin_en   (extin_en),
    .busy       (busy),
    .err_frame  (err_frame)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- observation of the write port ----------------
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [DATA_W-1:0] wr_data_q[$];
  logic              busy_at_en_q[$];
  int                err_cnt = 0;
  int                hold_viol = 0;
  int                en_long = 0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_data = '0;
  logic              prev_en = 1'b0;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_addr = '0;
      prev_data = '0;
      prev_en   = 1'b0;
    end else begin
      if (extin_en) begin
        wr_addr_q.push_back(extin_addr);
        wr_data_q.push_back(extin_data);
        busy_at_en_q.push_back(busy);
        if (prev_en) en_long++;
      end else if (extin_addr !== prev_addr || extin_data !== prev_data) begin
        hold_viol++;
      end
      if (err_frame) err_cnt++;
      prev_addr = extin_addr;
      prev_data = extin_data;
      prev_en   = extin_en;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] pb [NB];

  // Reference word: byte i of the packet occupies bits [DATA_W-1-8i -: 8].
  function automatic logic [DATA_W-1:0] model_word();
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < NB; i++) w[DATA_W-1-8*i -: 8] = pb[i];
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_tx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_tx = b[i];
      idle(CPB);
    end
    uart_tx = stop_bit;
    idle(CPB);
    uart_tx = 1'b1;
  endtask

  task automatic send_packet(input logic [7:0] a, input int gap);
    send_byte(a, 1'b1);
    idle(gap);
    for (int i = 0; i < NB; i++) begin
      send_byte(pb[i], 1'b1);
      idle(gap);
    end
  endtask

  task automatic wait_writes(input int n);
    int budget;
    budget = 200;
    while (wr_addr_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("write_count", DATA_W'(wr_addr_q.size()), DATA_W'(n));
  endtask

  task automatic check_write(input int idx, input string tag, input logic [7:0] a, input logic [DATA_W-1:0] d);
    if (wr_addr_q.size() > idx) begin
      chk({tag, "_addr"}, DATA_W'(wr_addr_q[idx]), DATA_W'(a[ADDR_W-1:0]));
      chk({tag, "_data"}, wr_data_q[idx], d);
    end else begin
      chk({tag, "_missing"}, DATA_W'(wr_addr_q.size()), DATA_W'(idx + 1));
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [DATA_W-1:0] exp1, exp2;
    logic [7:0]        ra;
    int                nw, e0;

    // Reset state
    idle(4);
    chk("rst_en",   DATA_W'(extin_en),   '0);
    chk("rst_addr", DATA_W'(extin_addr), '0);
    chk("rst_data", extin_data,          '0);
    chk("rst_busy", DATA_W'(busy),       '0);
    chk("rst_err",  DATA_W'(err_frame),  '0);
    rstn = 1'b1;
    idle(10);
    nw = 0;

    // Basic write: address 0x05, bytes 0x01..0x26
    for (int i = 0; i < NB; i++) pb[i] = 8'(i + 1);
    exp1 = model_word();
    send_packet(8'h05, 2);
    nw++;
    wait_writes(nw);
    check_write(nw - 1, "basic", 8'h05, exp1);
    if (busy_at_en_q.size() > 0) chk("basic_busy_at_en", DATA_W'(busy_at_en_q[0]), '0);
    idle(2);
    chk("basic_busy_after", DATA_W'(busy), '0);
    $display("txn basic addr=05 writes=%0d", wr_addr_q.size());

    // Glitch during idle
    e0 = err_cnt;
    uart_tx = 1'b0;
    idle(2);
    uart_tx = 1'b1;
    idle(30);
    chk("glitch_err",    DATA_W'(err_cnt), DATA_W'(e0));
    chk("glitch_writes", DATA_W'(wr_addr_q.size()), DATA_W'(nw));
    chk("glitch_busy",   DATA_W'(busy), '0);
    $display("txn glitch writes=%0d errs=%0d", wr_addr_q.size(), err_cnt);

    // Frame error on the 6th data byte, then a clean packet to 0x11
    send_byte(8'h10, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    send_byte(8'h3C, 1'b0);
    idle(20);
    chk("frame_err_cnt", DATA_W'(err_cnt), DATA_W'(e0 + 1));
    chk("frame_writes",  DATA_W'(wr_addr_q.size()), DATA_W'(nw));
    chk("frame_busy",    DATA_W'(busy), '0);
    for (int i = 0; i < NB; i++) pb[i] = 8'($urandom_range(0, 255));
    exp1 = model_word();
    send_packet(8'h11, 1);
    nw++;
    wait_writes(nw);
    check_write(nw - 1, "after_frame", 8'h11, exp1);
    $display("txn frame_error+recover addr=11 writes=%0d errs=%0d", wr_addr_q.size(), err_cnt);

    // Back-to-back packets with zero gap
    for (int i = 0; i < NB; i++) pb[i] = 8'hAA;
    exp1 = model_word();
    send_packet(8'h01, 0);
    for (int i = 0; i < NB; i++) pb[i] = 8'h55;
    exp2 = model_word();
    send_packet(8'h02, 0);
    nw += 2;
    wait_writes(nw);
    check_write(nw - 2, "b2b_first", 8'h01, exp1);
    check_write(nw - 1, "b2b_second", 8'h02, exp2);
    $display("txn back_to_back writes=%0d", wr_addr_q.size());

    // Partial packet leaves outputs untouched
    send_byte(8'h33, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    idle(30);
    chk("hold_addr",   DATA_W'(extin_addr), DATA_W'(8'h02));
    chk("hold_data",   extin_data, exp2);
    chk("hold_writes", DATA_W'(wr_addr_q.size()), DATA_W'(nw));
    $display("txn hold_partial addr=%0h writes=%0d", extin_addr, wr_addr_q.size());

    // Reset mid-packet after 10 data bytes (fresh packet after the reset)
    rstn = 1'b0;
    idle(3);
    rstn = 1'b1;
    idle(10);
    send_byte(8'h20, 1'b1);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_addr", DATA_W'(extin_addr), '0);
    chk("midrst_data", extin_data, '0);
    chk("midrst_busy", DATA_W'(busy), '0);
    chk("midrst_en",   DATA_W'(extin_en), '0);
    idle(3);
    rstn = 1'b1;
    idle(10);
    for (int i = 0; i < NB; i++) pb[i] = 8'($urandom_range(0, 255));
    exp1 = model_word();
    send_packet(8'h07, 0);
    nw++;
    wait_writes(nw);
    check_write(nw - 1, "after_reset", 8'h07, exp1);
    $display("txn reset_mid_packet addr=07 writes=%0d", wr_addr_q.size());

    // Random packets with random gaps
    for (int k = 0; k < 3; k++) begin
      ra = 8'($urandom_range(0, 255));
      for (int i = 0; i < NB; i++) pb[i] = 8'($urandom);
      exp1 = model_word();
      send_packet(ra, int'($urandom_range(0, 12)));
      nw++;
      wait_writes(nw);
      check_write(nw - 1, "random", ra, exp1);
      idle(int'($urandom_range(0, 20)));
      $display("txn random addr=%0h writes=%0d", ra, wr_addr_q.size());
    end

    chk("final_hold_violations", DATA_W'(hold_viol), '0);
    chk("final_en_width",        DATA_W'(en_long), '0);
    chk("final_err_total",       DATA_W'(err_cnt), DATA_W'(e0 + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
